// File: rtl/avalon_msg_generator.sv
// rtl/avalon_msg_generator.sv - Avalon-ST source emitting one framed incrementing-byte message per start pulse
// Byte 0 of each beat sits in the MSB lane; the last beat zero-fills its unused low lanes.
module avalon_msg_generator #(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int LEN_WIDTH           = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [LEN_WIDTH-1:0]                 msg_len_bytes,
    input  logic [7:0]                           seed,
    output logic                                 msg_out_valid,
    output logic [8*DATA_WIDTH_IN_BYTES-1:0]     msg_out_data,
    output logic                                 msg_out_sop,
    output logic                                 msg_out_eop,
    output logic [$clog2(DATA_WIDTH_IN_BYTES)-1:0] msg_out_empty,
    input  logic                                 msg_out_ready,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 len_err
);

    localparam int W  = DATA_WIDTH_IN_BYTES;
    localparam int EW = $clog2(W);
    localparam int DW = 8 * W;
    localparam int BW = LEN_WIDTH - EW + 1;
    localparam logic [7:0] W_STEP = 8'(W % 256);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   rem_q, rem_d;
    logic [7:0]      next_byte_q, next_byte_d;
    logic [EW-1:0]   last_empty_q, last_empty_d;
    logic [DW-1:0]   data_q, data_d;
    logic            sop_q, sop_d;
    logic            eop_q, eop_d;
    logic [EW-1:0]   empty_q, empty_d;
    logic            done_q, done_d;
    logic            len_err_q, len_err_d;

    logic [BW-1:0]   req_beats;
    logic [EW-1:0]   req_empty;
    logic            req_ok;
    logic            xfer;

    function automatic logic [DW-1:0] build_beat(input logic [7:0] first, input logic [EW-1:0] empty);
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < W; i++) begin
            if (i < W - int'(empty)) begin
                d[DW-1-8*i -: 8] = first + 8'(i);
            end
        end
        return d;
    endfunction

    // One extra counter bit so ceil(2^LEN_WIDTH-1 / W) never wraps
    assign req_beats = BW'(({1'b0, msg_len_bytes} + (LEN_WIDTH+1)'(W - 1)) >> EW);
    assign req_empty = ~msg_len_bytes[EW-1:0] + EW'(1);
    assign req_ok    = start && (msg_len_bytes != '0);
    assign xfer      = (state_q == SEND) && msg_out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            next_byte_q  <= '0;
            last_empty_q <= '0;
            data_q       <= '0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            empty_q      <= '0;
            done_q       <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            next_byte_q  <= next_byte_d;
            last_empty_q <= last_empty_d;
            data_q       <= data_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            empty_q      <= empty_d;
            done_q       <= done_d;
            len_err_q    <= len_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_ok) state_d = SEND;
            SEND:    if (xfer && eop_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rem_d        = rem_q;
        next_byte_d  = next_byte_q;
        last_empty_d = last_empty_q;
        data_d       = data_q;
        sop_d        = sop_q;
        eop_d        = eop_q;
        empty_d      = empty_q;
        done_d       = 1'b0;
        len_err_d    = 1'b0;
        if (state_q == IDLE) begin
            if (start && (msg_len_bytes == '0)) begin
                len_err_d = 1'b1;
            end else if (req_ok) begin
                rem_d        = req_beats - BW'(1);
                last_empty_d = req_empty;
                next_byte_d  = seed + W_STEP;
                sop_d        = 1'b1;
                eop_d        = (req_beats == BW'(1));
                empty_d      = eop_d ? req_empty : '0;
                data_d       = build_beat(seed, empty_d);
            end
        end else if (xfer) begin
            if (eop_q) begin
                rem_d   = '0;
                data_d  = '0;
                sop_d   = 1'b0;
                eop_d   = 1'b0;
                empty_d = '0;
                done_d  = 1'b1;
            end else begin
                // rem_q counts beats still to come after the one on the bus
                rem_d       = rem_q - BW'(1);
                sop_d       = 1'b0;
                eop_d       = (rem_q == BW'(1));
                empty_d     = eop_d ? last_empty_q : '0;
                data_d      = build_beat(next_byte_q, empty_d);
                next_byte_d = next_byte_q + W_STEP;
            end
        end
    end

    always_comb begin
        msg_out_valid = (state_q == SEND);
        busy          = (state_q == SEND);
        msg_out_data  = data_q;
        msg_out_sop   = sop_q;
        msg_out_eop   = eop_q;
        msg_out_empty = empty_q;
        done          = done_q;
        len_err       = len_err_q;
    end

endmodule

// File: tb/tb_avalon_msg_generator.sv
// tb/tb_avalon_msg_generator.sv - self-checking bench for avalon_msg_generator
module tb_avalon_msg_generator;

    localparam int W  = 16;
    localparam int DW = 8 * W;
    localparam int EW = $clog2(W);
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] len;
    logic [7:0]    seed;
    logic          ready;
    logic          valid;
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic          busy;
    logic          done;
    logic          len_err;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
    } beat_t;

    beat_t exp_q[$];
    beat_t log_q[$];
    bit    exp_done;
    bit    exp_lenerr;
    int    errors = 0;
    int    checks = 0;
    int    lenerr_seen = 0;
    int    n;

    avalon_msg_generator #(.DATA_WIDTH_IN_BYTES(W), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .msg_len_bytes(len), .seed(seed),
        .msg_out_valid(valid), .msg_out_data(data), .msg_out_sop(sop), .msg_out_eop(eop),
        .msg_out_empty(empty), .msg_out_ready(ready),
        .busy(busy), .done(done), .len_err(len_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic void push_msg(input int l, input logic [7:0] s);
        int nb;
        beat_t x;
        nb = (l + W - 1) / W;
        for (int b = 0; b < nb; b++) begin
            x = '0;
            for (int i = 0; i < W; i++) begin
                if (b * W + i < l) x.data[DW-1-8*i -: 8] = 8'((int'(s) + b * W + i) % 256);
            end
            x.sop   = (b == 0);
            x.eop   = (b == nb - 1);
            x.empty = (b == nb - 1) ? EW'(nb * W - l) : '0;
            exp_q.push_back(x);
        end
    endfunction

    // Reference model steps on the rising edge; outputs compared on the falling edge
    initial begin
        bit was_busy;
        bit exp_v;
        forever begin
            @(posedge clk);
            if (rst) begin
                was_busy   = (exp_q.size() != 0);
                exp_done   = 1'b0;
                exp_lenerr = 1'b0;
                if (was_busy) begin
                    if (ready) begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) exp_done = 1'b1;
                    end
                end else if (start) begin
                    if (len == '0) exp_lenerr = 1'b1;
                    else push_msg(int'(len), seed);
                end
            end
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                exp_done   = 1'b0;
                exp_lenerr = 1'b0;
            end
            exp_v = (exp_q.size() != 0);
            check("ctrl", 256'({valid, busy, done, len_err}), 256'({exp_v, exp_v, exp_done, exp_lenerr}));
            if (exp_v) check("beat", 256'({data, sop, eop, empty}), 256'(exp_q[0]));
            else if (!rst) check("rst_fields", 256'({data, sop, eop, empty}), 256'(0));
            if (valid && ready) log_q.push_back({data, sop, eop, empty});
            if (len_err) lenerr_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int l, input logic [7:0] s);
        start = 1'b1;
        len   = LW'(l);
        seed  = s;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cnt);
        cnt = 0;
        while (cnt < budget && !done) begin
            tick();
            cnt++;
        end
        check("done_seen", 256'(done), 256'(1));
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; len = '0; seed = '0; ready = 1'b1;
        repeat (3) tick();
        check("reset_state", 256'({valid, busy, done, len_err, sop, eop, empty, data}), 256'(0));
        rst = 1'b1;
        tick();

        log_q.delete();
        send(40, 8'h10);
        wait_done(20, n);
        check("t1_latency", 256'(n), 256'(3));
        check("t1_nbeats", 256'(log_q.size()), 256'(3));
        check("t1_b0", 256'(log_q[0]), 256'({128'h101112131415161718191a1b1c1d1e1f, 1'b1, 1'b0, 4'd0}));
        check("t1_b1", 256'(log_q[1]), 256'({128'h202122232425262728292a2b2c2d2e2f, 1'b0, 1'b0, 4'd0}));
        check("t1_b2", 256'(log_q[2]), 256'({128'h30313233343536370000000000000000, 1'b0, 1'b1, 4'd8}));
        tick();

        log_q.delete();
        send(16, 8'hF8);
        wait_done(20, n);
        check("t2_nbeats", 256'(log_q.size()), 256'(1));
        check("t2_b0", 256'(log_q[0]), 256'({128'hf8f9fafbfcfdfeff0001020304050607, 1'b1, 1'b1, 4'd0}));
        tick();

        log_q.delete();
        send(33, 8'h00);
        for (int i = 0; i < 40 && !done; i++) begin
            ready = (i % 3 == 0);
            tick();
        end
        check("t3_done_seen", 256'(done), 256'(1));
        ready = 1'b1;
        check("t3_nbeats", 256'(log_q.size()), 256'(3));
        check("t3_b0", 256'(log_q[0]), 256'({128'h000102030405060708090a0b0c0d0e0f, 1'b1, 1'b0, 4'd0}));
        check("t3_b2", 256'(log_q[2]), 256'({128'h20000000000000000000000000000000, 1'b0, 1'b1, 4'd15}));
        tick();

        log_q.delete();
        lenerr_seen = 0;
        send(0, 8'h55);
        repeat (3) tick();
        check("t4_lenerr_count", 256'(lenerr_seen), 256'(1));
        check("t4_nbeats", 256'(log_q.size()), 256'(0));

        log_q.delete();
        send(20, 8'h40);
        start = 1'b1;
        len   = LW'(20);
        tick();
        start = 1'b0;
        wait_done(20, n);
        repeat (4) tick();
        check("t5_nbeats", 256'(log_q.size()), 256'(2));
        check("t5_b1", 256'(log_q[1]), 256'({128'h50515253000000000000000000000000, 1'b0, 1'b1, 4'd12}));

        log_q.delete();
        send(64, 8'h80);
        tick();
        rst = 1'b0;
        #1;
        check("t6_rst_immediate", 256'({valid, sop, eop, busy}), 256'(0));
        repeat (2) tick();
        rst = 1'b1;
        tick();
        send(16, 8'h00);
        wait_done(20, n);
        check("t6_nbeats", 256'(log_q.size()), 256'(2));
        check("t6_b0", 256'(log_q[0]), 256'({128'h808182838485868788898a8b8c8d8e8f, 1'b1, 1'b0, 4'd0}));
        check("t6_fresh", 256'(log_q[1]), 256'({128'h000102030405060708090a0b0c0d0e0f, 1'b1, 1'b1, 4'd0}));
        tick();

        log_q.delete();
        send(65535, 8'h01);
        wait_done(5000, n);
        check("t7_nbeats", 256'(log_q.size()), 256'(4096));
        check("t7_last", 256'(log_q[4095]), 256'({128'hf1f2f3f4f5f6f7f8f9fafbfcfdfeff00, 1'b0, 1'b1, 4'd1}));
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
